// File: rtl/demo_pulse_seq.sv
// Rotating A->B->C->D single-cycle pulse generator with a programmable idle gap after each pulse.
// Latency 1 from enable to first pulse; enable is a level request, a started pulse always completes.
module demo_pulse_seq #(
  parameter int GAP_W   = 4,
  parameter int ROUND_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [GAP_W-1:0]   gap,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               D,
  output logic [1:0]         phase,
  output logic               busy,
  output logic [ROUND_W-1:0] rounds
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [GAP_W-1:0]   r_cnt;
  logic [1:0]         r_phase;
  logic [ROUND_W-1:0] r_rounds;
  logic [3:0]         r_pulse;
  logic               r_busy;

  logic w_slot_open;
  logic w_fire;
  logic w_to_wait;

  // A new pulse may launch from IDLE, straight after a zero-gap pulse, or on the last WAIT cycle.
  assign w_slot_open = (r_state == S_IDLE) ||
                       ((r_state == S_PULSE) && (r_cnt == '0)) ||
                       ((r_state == S_WAIT) && (r_cnt <= GAP_W'(1)));
  assign w_fire      = w_slot_open && enable;
  assign w_to_wait   = (r_state == S_PULSE) && (r_cnt != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_phase  <= 2'd0;
      r_rounds <= '0;
      r_pulse  <= 4'b0000;
      r_busy   <= 1'b0;
    end else begin
      r_pulse <= 4'b0000;
      if (w_fire) begin
        r_state <= S_PULSE;
        r_busy  <= 1'b1;
        r_pulse <= 4'b0001 << r_phase;
        r_cnt   <= gap;
        r_phase <= r_phase + 2'd1;
        if (r_phase == 2'd3) begin
          r_rounds <= r_rounds + 1'b1;
        end
      end else if (w_to_wait) begin
        r_state <= S_WAIT;
        r_busy  <= 1'b1;
      end else if (w_slot_open) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign A      = r_pulse[0];
  assign B      = r_pulse[1];
  assign C      = r_pulse[2];
  assign D      = r_pulse[3];
  assign phase  = r_phase;
  assign busy   = r_busy;
  assign rounds = r_rounds;

endmodule

// File: tb/tb_demo_pulse_seq.sv
// Scenario bench for demo_pulse_seq: expected pulses are queued as stimulus is applied,
// observed pulses are collected each cycle, and each scenario drains and compares the two queues.
module tb_demo_pulse_seq;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] gap;
  logic       A, B, C, D;
  logic [1:0] phase;
  logic       busy;
  logic [7:0] rounds;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
    logic [7:0] rnd;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e, o;
  int  cyc;
  int  checks;
  int  errors;

  demo_pulse_seq #(.GAP_W(4), .ROUND_W(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .gap    (gap),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .phase  (phase),
    .busy   (busy),
    .rounds (rounds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to the next falling edge and log any pulse seen in the cycle just launched.
  task automatic step();
    @(negedge clock);
    cyc = cyc + 1;
    if ({D, C, B, A} != 4'b0000) begin
      obs_q.push_back('{cyc, {D, C, B, A}, rounds});
    end
  endtask

  task automatic push_exp(input int c, input int idx, input int rnd);
    logic [3:0] v;
    v = 4'b0001 << idx;
    exp_q.push_back('{c, v, 8'(rnd)});
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    enable = 1'b0;
    gap    = 4'd0;
    repeat (2) step();
    reset = 1'b1;
    step();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b0;
    gap    = 4'd0;
    step();
    checks++; if ({D, C, B, A} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got=%b want=0000", {D, C, B, A}); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d want=0", phase); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (rounds !== 8'd0) begin errors++; $display("FAIL reset_rounds got=%0d want=0", rounds); end
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || {D, C, B, A} !== 4'b0000) begin errors++; $display("FAIL reset_idle_hold busy=%b pulses=%b want 0/0000", busy, {D, C, B, A}); end
  endtask

  task automatic test_back_to_back();
    int k;
    apply_reset();
    k = cyc;
    gap = 4'd0; enable = 1'b1;
    push_exp(k + 1, 0, 0); push_exp(k + 2, 1, 0); push_exp(k + 3, 2, 0);
    push_exp(k + 4, 3, 1); push_exp(k + 5, 0, 1);
    repeat (5) step();
    enable = 1'b0;
    repeat (4) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b want=0", busy); end
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL b2b_phase got=%0d want=1", phase); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_pulse missing: want vec=%b at cyc %0d", e.vec, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vec !== e.vec || o.rnd !== e.rnd) begin
          errors++; $display("FAIL b2b_pulse got cyc=%0d vec=%b rnd=%0d want cyc=%0d vec=%b rnd=%0d", o.cyc, o.vec, o.rnd, e.cyc, e.vec, e.rnd);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra got=%0d extra pulses want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_gap2();
    int k;
    apply_reset();
    k = cyc;
    gap = 4'd2; enable = 1'b1;
    push_exp(k + 1, 0, 0); push_exp(k + 4, 1, 0); push_exp(k + 7, 2, 0); push_exp(k + 10, 3, 1);
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap2_busy cyc=%0d got=%b want=1", i, busy); end
    end
    enable = 1'b0;
    repeat (2) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap2_tail_busy got=%b want=1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap2_idle_busy got=%b want=0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL gap2_pulse missing: want vec=%b at cyc %0d", e.vec, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vec !== e.vec || o.rnd !== e.rnd) begin
          errors++; $display("FAIL gap2_pulse got cyc=%0d vec=%b rnd=%0d want cyc=%0d vec=%b rnd=%0d", o.cyc, o.vec, o.rnd, e.cyc, e.vec, e.rnd);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL gap2_extra got=%0d extra pulses want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_enable_drop();
    int k;
    apply_reset();
    k = cyc;
    gap = 4'd3; enable = 1'b1;
    push_exp(k + 1, 0, 0); push_exp(k + 5, 1, 0);
    repeat (5) step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_wait_busy i=%0d got=%b want=1", i, busy); end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got=%b want=0", busy); end
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL drop_idle_phase got=%0d want=2", phase); end
    repeat (5) step();
    gap = 4'd0; enable = 1'b1;
    push_exp(cyc + 1, 2, 0);
    step();
    enable = 1'b0;
    repeat (3) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL drop_pulse missing: want vec=%b at cyc %0d", e.vec, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vec !== e.vec || o.rnd !== e.rnd) begin
          errors++; $display("FAIL drop_pulse got cyc=%0d vec=%b rnd=%0d want cyc=%0d vec=%b rnd=%0d", o.cyc, o.vec, o.rnd, e.cyc, e.vec, e.rnd);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL drop_extra got=%0d extra pulses want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_gap_change();
    int k;
    apply_reset();
    k = cyc;
    gap = 4'd3; enable = 1'b1;
    push_exp(k + 1, 0, 0); push_exp(k + 5, 1, 0); push_exp(k + 6, 2, 0);
    repeat (2) step();
    gap = 4'd0;
    repeat (4) step();
    enable = 1'b0;
    repeat (3) step();
    checks++; if (phase !== 2'd3) begin errors++; $display("FAIL gapchg_phase got=%0d want=3", phase); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL gapchg_pulse missing: want vec=%b at cyc %0d", e.vec, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vec !== e.vec || o.rnd !== e.rnd) begin
          errors++; $display("FAIL gapchg_pulse got cyc=%0d vec=%b rnd=%0d want cyc=%0d vec=%b rnd=%0d", o.cyc, o.vec, o.rnd, e.cyc, e.vec, e.rnd);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL gapchg_extra got=%0d extra pulses want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_in_wait();
    int k;
    apply_reset();
    k = cyc;
    gap = 4'd0; enable = 1'b1;
    push_exp(k + 1, 0, 0); push_exp(k + 2, 1, 0); push_exp(k + 3, 2, 0);
    push_exp(k + 4, 3, 1); push_exp(k + 5, 0, 1); push_exp(k + 6, 1, 1);
    push_exp(k + 7, 2, 1);
    repeat (6) step();
    gap = 4'd3;
    repeat (2) step();
    checks++; if (busy !== 1'b1 || rounds !== 8'd1) begin errors++; $display("FAIL rstwait_pre busy=%b rounds=%0d want 1/1", busy, rounds); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({D, C, B, A} !== 4'b0000) begin errors++; $display("FAIL rstwait_pulses got=%b want=0000", {D, C, B, A}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstwait_busy got=%b want=0", busy); end
    checks++; if (rounds !== 8'd0) begin errors++; $display("FAIL rstwait_rounds got=%0d want=0", rounds); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rstwait_phase got=%0d want=0", phase); end
    gap = 4'd0;
    step();
    reset = 1'b1;
    push_exp(cyc + 1, 0, 0);
    step();
    enable = 1'b0;
    repeat (2) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rstwait_pulse missing: want vec=%b at cyc %0d", e.vec, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vec !== e.vec || o.rnd !== e.rnd) begin
          errors++; $display("FAIL rstwait_pulse got cyc=%0d vec=%b rnd=%0d want cyc=%0d vec=%b rnd=%0d", o.cyc, o.vec, o.rnd, e.cyc, e.vec, e.rnd);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstwait_extra got=%0d extra pulses want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_rounds_wrap();
    int k;
    int bad;
    apply_reset();
    k = cyc;
    gap = 4'd0; enable = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      push_exp(k + 1 + i, i % 4, ((i / 4) + ((i % 4 == 3) ? 1 : 0)) % 256);
    end
    repeat (1024) step();
    enable = 1'b0;
    repeat (2) step();
    checks++; if (rounds !== 8'd0) begin errors++; $display("FAIL wrap_rounds_final got=%0d want=0", rounds); end
    bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; bad++;
        if (bad <= 4) $display("FAIL wrap_pulse missing: want vec=%b at cyc %0d", e.vec, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vec !== e.vec || o.rnd !== e.rnd) begin
          errors++; bad++;
          if (bad <= 4) $display("FAIL wrap_pulse got cyc=%0d vec=%b rnd=%0d want cyc=%0d vec=%b rnd=%0d", o.cyc, o.vec, o.rnd, e.cyc, e.vec, e.rnd);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_extra got=%0d extra pulses want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    enable = 1'b0;
    gap    = 4'd0;
    test_reset();
    test_back_to_back();
    test_gap2();
    test_enable_drop();
    test_gap_change();
    test_reset_in_wait();
    test_rounds_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
